// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream FIFO port bundle: upstream beat, downstream beat and fill status.
// The slave modport is the FIFO side; master is the side driving it.
interface axis_pkt_fifo_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic [CW-1:0] count;
  logic [CW-1:0] pkt_count;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast,
    output count, pkt_count
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast,
    input  count, pkt_count
  );
endinterface

// File: rtl/axis_pkt_fifo.sv
// First-word-fall-through AXI-Stream FIFO with optional store-and-forward
// gating and word / complete-packet occupancy counters.
module axis_pkt_fifo #(
  parameter int DW       = 8,
  parameter int DEPTH    = 16,
  parameter int PKT_MODE = 0
) (
  input logic            clk,
  input logic            rst,
  axis_pkt_fifo_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DW:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pkt_q, pkt_d;
  logic          rdy_q, rdy_d;
  logic          cut_q, cut_d;
  logic          push, pop, vld, head_last;
  logic          pkt_in, pkt_out;

  assign head_last = mem_q[rd_q][DW];

  // cut lets an oversize packet drain once it alone fills the FIFO
  assign vld = (cnt_q != '0) &&
               ((PKT_MODE == 0) || (pkt_q != '0) || cut_q);

  assign push    = io.s_tvalid && rdy_q;
  assign pop     = vld && io.m_tready;
  assign pkt_in  = push && io.s_tlast;
  assign pkt_out = pop && head_last;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    pkt_d = pkt_q;
    cut_d = cut_q;
    rdy_d = rdy_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    unique case ({pkt_in, pkt_out})
      2'b10:   pkt_d = pkt_q + CW'(1);
      2'b01:   pkt_d = pkt_q - CW'(1);
      default: pkt_d = pkt_q;
    endcase
    rdy_d = (cnt_d != FULL);
    if (pkt_out)
      cut_d = 1'b0;
    else if ((PKT_MODE != 0) && (cnt_d == FULL) && (pkt_d == '0))
      cut_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      pkt_q <= '0;
      rdy_q <= 1'b0;
      cut_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      pkt_q <= pkt_d;
      rdy_q <= rdy_d;
      cut_q <= cut_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {io.s_tlast, io.s_tdata};
  end

  assign io.s_tready  = rdy_q;
  assign io.m_tvalid  = vld;
  assign io.m_tdata   = mem_q[rd_q][DW-1:0];
  assign io.m_tlast   = head_last;
  assign io.count     = cnt_q;
  assign io.pkt_count = pkt_q;
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench: cut-through instance A and store-and-forward instance B
// share one stimulus; each phase checks the instance it targets.
module tb_axis_pkt_fifo;
  logic       clk;
  logic       rst;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       m_tready;

  int npass = 0;
  int ntot  = 0;

  axis_pkt_fifo_if #(.DW(8), .DEPTH(16)) ifa ();
  axis_pkt_fifo_if #(.DW(8), .DEPTH(16)) ifb ();

  assign ifa.s_tdata  = s_tdata;
  assign ifa.s_tvalid = s_tvalid;
  assign ifa.s_tlast  = s_tlast;
  assign ifa.m_tready = m_tready;
  assign ifb.s_tdata  = s_tdata;
  assign ifb.s_tvalid = s_tvalid;
  assign ifb.s_tlast  = s_tlast;
  assign ifb.m_tready = m_tready;

  axis_pkt_fifo #(.DW(8), .DEPTH(16), .PKT_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .io(ifa.slave)
  );
  axis_pkt_fifo #(.DW(8), .DEPTH(16), .PKT_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .io(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       use_b;
    bit       rstv;
    bit       tv;
    bit [7:0] td;
    bit       tl;
    bit       rdy;
    bit       e_tr;
    bit       e_v;
    bit [7:0] e_d;
    bit       e_l;
    int       e_cnt;
    int       e_pkt;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(bit b, bit r, bit tv, bit [7:0] td, bit tl,
                              bit rdy, bit etr, bit ev, bit [7:0] ed,
                              bit el, int ec, int ep);
    vec_t v;
    v.use_b = b; v.rstv = r; v.tv = tv; v.td = td; v.tl = tl;
    v.rdy = rdy; v.e_tr = etr; v.e_v = ev; v.e_d = ed; v.e_l = el;
    v.e_cnt = ec; v.e_pkt = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step(input bit tv, input bit [7:0] td, input bit tl,
                      input bit rdy);
    @(negedge clk);
    s_tvalid = tv;
    s_tdata  = td;
    s_tlast  = tl;
    m_tready = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit [8:0] q[$];
    bit [8:0] got[$];
    bit [7:0] hd;
    int k;
    bit seen16, seen15, tv, acc;

    rst = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    m_tready = 1'b0;

    // cut-through on A, then store-and-forward packet on B
    tbl[0]  = mk(0,0,0,8'h00,0,0, 0,0,8'h00,0,0,0);
    tbl[1]  = mk(0,1,0,8'h00,0,0, 0,0,8'h00,0,0,0);
    tbl[2]  = mk(0,1,1,8'h01,0,1, 1,0,8'h00,0,0,0);
    for (int i = 3; i <= 10; i++)
      tbl[i] = mk(0,1,1,8'(i-1),(i == 10),1, 1,1,8'(i-2),0,1,0);
    tbl[11] = mk(0,1,0,8'h00,0,1, 1,1,8'h09,1,1,1);
    tbl[12] = mk(0,1,0,8'h00,0,1, 1,0,8'h00,0,0,0);
    tbl[13] = mk(1,0,0,8'h00,0,0, 0,0,8'h00,0,0,0);
    tbl[14] = mk(1,1,0,8'h00,0,0, 0,0,8'h00,0,0,0);
    for (int i = 15; i <= 19; i++)
      tbl[i] = mk(1,1,1,8'(8'h11+i-15),(i == 19),1, 1,0,8'h00,0,i-15,0);
    for (int i = 20; i <= 24; i++)
      tbl[i] = mk(1,1,0,8'h00,0,1, 1,1,8'(8'h11+i-20),(i == 24),25-i,1);
    tbl[25] = mk(1,1,0,8'h00,0,1, 1,0,8'h00,0,0,0);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      rst      = tbl[i].rstv;
      s_tvalid = tbl[i].tv;
      s_tdata  = tbl[i].td;
      s_tlast  = tbl[i].tl;
      m_tready = tbl[i].rdy;
      #1;
      if (tbl[i].use_b) begin
        chk($sformatf("tbl%0d.tready", i), ifb.s_tready, tbl[i].e_tr);
        chk($sformatf("tbl%0d.tvalid", i), ifb.m_tvalid, tbl[i].e_v);
        chk($sformatf("tbl%0d.count", i), ifb.count, tbl[i].e_cnt);
        chk($sformatf("tbl%0d.pkt", i), ifb.pkt_count, tbl[i].e_pkt);
        if (tbl[i].e_v) begin
          chk($sformatf("tbl%0d.data", i), ifb.m_tdata, tbl[i].e_d);
          chk($sformatf("tbl%0d.last", i), ifb.m_tlast, tbl[i].e_l);
        end
      end else begin
        chk($sformatf("tbl%0d.tready", i), ifa.s_tready, tbl[i].e_tr);
        chk($sformatf("tbl%0d.tvalid", i), ifa.m_tvalid, tbl[i].e_v);
        chk($sformatf("tbl%0d.count", i), ifa.count, tbl[i].e_cnt);
        chk($sformatf("tbl%0d.pkt", i), ifa.pkt_count, tbl[i].e_pkt);
        if (tbl[i].e_v) begin
          chk($sformatf("tbl%0d.data", i), ifa.m_tdata, tbl[i].e_d);
          chk($sformatf("tbl%0d.last", i), ifa.m_tlast, tbl[i].e_l);
        end
      end
    end

    // fill to full with consumer stalled, then drain
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(8'h20 + i), 0, 0);
      chk($sformatf("fill%0d.tready", i), ifa.s_tready, (i < 16));
      chk($sformatf("fill%0d.count", i), ifa.count, (i < 16) ? i : 16);
    end
    for (int j = 0; j < 16; j++) begin
      step(0, 8'h00, 0, 1);
      chk($sformatf("drain%0d.tvalid", j), ifa.m_tvalid, 1);
      chk($sformatf("drain%0d.data", j), ifa.m_tdata, 8'h20 + j);
      chk($sformatf("drain%0d.tready", j), ifa.s_tready, (j > 0));
      chk($sformatf("drain%0d.count", j), ifa.count, 16 - j);
    end
    step(0, 8'h00, 0, 0);
    chk("drain.empty_valid", ifa.m_tvalid, 0);
    chk("drain.empty_count", ifa.count, 0);

    // steady push+pop at count 5 straddling pointer wrap
    do_reset();
    q.delete();
    for (int i = 0; i < 12; i++) begin
      step(1, 8'(8'h40 + i), 0, 0);
      q.push_back({1'b0, 8'(8'h40 + i)});
    end
    for (int i = 0; i < 7; i++) begin
      step(0, 8'h00, 0, 1);
      hd = q[0][7:0];
      chk($sformatf("pre%0d.data", i), ifa.m_tdata, hd);
      void'(q.pop_front());
    end
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(8'h4C + i), 0, 1);
      hd = q[0][7:0];
      chk($sformatf("wrap%0d.count", i), ifa.count, 5);
      chk($sformatf("wrap%0d.tvalid", i), ifa.m_tvalid, 1);
      chk($sformatf("wrap%0d.data", i), ifa.m_tdata, hd);
      void'(q.pop_front());
      q.push_back({1'b0, 8'(8'h4C + i)});
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 0, 1);
      hd = q[0][7:0];
      chk($sformatf("tail%0d.data", i), ifa.m_tdata, hd);
      void'(q.pop_front());
    end
    step(0, 8'h00, 0, 0);
    chk("tail.empty", ifa.m_tvalid, 0);

    // oversize packet in store-and-forward mode
    do_reset();
    got.delete();
    k = 0; seen16 = 0; seen15 = 0;
    for (int c = 0; c < 100; c++) begin
      tv = (k < 20);
      step(tv, 8'(8'h60 + k), (k == 19), 1);
      acc = tv && ifb.s_tready;
      if (!seen15 && ifb.count == 15) begin
        seen15 = 1;
        chk("ovf.hold_valid", ifb.m_tvalid, 0);
      end
      if (!seen16 && ifb.count == 16) begin
        seen16 = 1;
        chk("ovf.cut_valid", ifb.m_tvalid, 1);
      end
      if (ifb.m_tvalid) got.push_back({ifb.m_tlast, ifb.m_tdata});
      if (acc) k++;
      if (k == 20 && got.size() == 20) break;
    end
    chk("ovf.seen_full", seen16, 1);
    chk("ovf.beats", got.size(), 20);
    for (int i = 0; i < got.size() && i < 20; i++) begin
      chk($sformatf("ovf%0d.data", i), got[i][7:0], 8'h60 + i);
      chk($sformatf("ovf%0d.last", i), got[i][8], (i == 19));
    end
    step(0, 8'h00, 0, 1);
    chk("ovf.end_count", ifb.count, 0);
    chk("ovf.end_pkt", ifb.pkt_count, 0);

    // asynchronous reset in the middle of a packet
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 8'(8'h70 + i), (i == 2), 0);
    step(0, 8'h00, 0, 0);
    chk("mid.count", ifa.count, 7);
    chk("mid.pkt", ifa.pkt_count, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst.count", ifa.count, 0);
    chk("rst.pkt", ifa.pkt_count, 0);
    chk("rst.tvalid", ifa.m_tvalid, 0);
    chk("rst.tready", ifa.s_tready, 0);
    chk("rst.b_count", ifb.count, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel.tready_pre", ifa.s_tready, 0);
    step(1, 8'h81, 0, 0);
    chk("rel.tready", ifa.s_tready, 1);
    step(1, 8'h82, 0, 0);
    step(1, 8'h83, 1, 0);
    step(0, 8'h00, 0, 1);
    chk("new.count", ifa.count, 3);
    chk("new.pkt", ifa.pkt_count, 1);
    chk("new.d0", ifa.m_tdata, 8'h81);
    step(0, 8'h00, 0, 1);
    chk("new.d1", ifa.m_tdata, 8'h82);
    step(0, 8'h00, 0, 1);
    chk("new.d2", ifa.m_tdata, 8'h83);
    chk("new.last", ifa.m_tlast, 1);
    step(0, 8'h00, 0, 1);
    chk("new.empty", ifa.m_tvalid, 0);
    chk("new.pkt0", ifa.pkt_count, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/axis_pkt_fifo.md
# axis_pkt_fifo

Synchronous AXI-Stream FIFO that sits directly downstream of the 2:1 stream mux and buffers the selected stream (tdata/tlast) before the consumer. It decouples consumer back-pressure from the mux's source selection. An optional store-and-forward mode holds output until a complete packet (tlast) is stored, so a packet is never presented with gaps. It also reports word occupancy and the number of complete packets stored.

## Interface
- DW, 8, data width in bits
- DEPTH, 16, storage depth in words; power of 2, ≥ 2
- PKT_MODE, 0, 0 = cut-through (output as soon as a word is stored); 1 = store-and-forward
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-low
- s_tdata  in  DW  input data (from mux m_tdata)
- s_tvalid  in  1  input valid
- s_tlast  in  1  input last beat of packet
- s_tready  out  1  FIFO can accept a beat
- m_tdata  out  DW  output data
- m_tvalid  out  1  output beat available
- m_tlast  out  1  output last beat of packet
- m_tready  in  1  consumer accepts beat
- count  out  $clog2(DEPTH)+1  words stored, 0..DEPTH
- pkt_count  out  $clog2(DEPTH)+1  complete packets stored (tlast beats in FIFO), 0..DEPTH

## Operation
- Storage: DEPTH×(DW+1) memory holding {tlast, tdata}; write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Memory contents are not reset.
- Push when s_tvalid && s_tready. Pop when m_tvalid && m_tready.
- s_tready = (count != DEPTH), registered. No push-through-when-full: a full FIFO deasserts s_tready even if a pop occurs in the same cycle.
- First-word-fall-through: m_tdata/m_tlast show the word at the read pointer whenever m_tvalid=1. When m_tvalid=0 they are don't-care.
- count: +1 on push only, −1 on pop only, unchanged on push+pop or neither.
- pkt_count: +1 on push with s_tlast=1, −1 on pop with m_tlast=1, unchanged on both or neither. This is maintained in both modes.
- PKT_MODE=0: m_tvalid = (count != 0).
- PKT_MODE=1: m_tvalid = (count != 0) && (pkt_count != 0 || cut).
  - cut is an internal flag that prevents deadlock on oversize packets.
  - cut is set when count == DEPTH and pkt_count == 0.
  - cut is cleared on a pop with m_tlast=1.
  - While cut=1, the partial packet drains in cut-through fashion until its tlast.
- A packet longer than DEPTH in PKT_MODE=1 is therefore passed whole, but it may show m_tvalid gaps after the cut.

## Timing
- Reset (rst=0, asynchronous): s_tready=0, m_tvalid=0, count=0, pkt_count=0, cut=0, pointers=0; m_tlast and m_tdata are don't-care.
- After rst rises: s_tready=1 from the first rising edge onward.
- Latency, cut-through: a beat pushed at edge N is presented with m_tvalid=1 after edge N (one cycle). count and pkt_count also update at edge N.
- Latency, store-and-forward: m_tvalid rises after the edge at which the tlast beat is pushed.
- Throughput: one beat per cycle sustained when m_tready=1 and the FIFO is non-empty and non-full.
- Full: count == DEPTH → s_tready=0 after that edge. s_tready returns to 1 one cycle after the first pop.
- Empty: after the pop that empties the FIFO, m_tvalid=0 in the next cycle.
- Pointer wrap: a pointer at DEPTH−1 advances to 0; there is no effect on count.
- m_tvalid, once asserted, stays high with stable data until popped. The exception is reset.
- Reset mid-packet: all state clears immediately. Partial packets are discarded, and the next beat after reset starts a new packet.

## Test plan
- Cut-through, DEPTH=16: push 9 beats 0x01..0x09 with m_tready=1 → m_tvalid asserts 1 cycle after the first push; the output order is identical; count never exceeds 1.
- Fill/full, DEPTH=16: m_tready=0, push 20 beats → exactly 16 are accepted; s_tready=0 after the 16th edge; count=16. Then m_tready=1 → the 16 beats emerge in order; s_tready=1 one cycle after the first pop.
- Simultaneous push/pop at count=5 for 10 cycles → count stays 5; the output sequence is continuous. Run this across a pointer wrap.
- PKT_MODE=1: push a 5-beat packet (tlast on beat 5) with m_tready=1 → m_tvalid=0 until after the tlast push, then 5 back-to-back beats; pkt_count goes 0→1→0.
- PKT_MODE=1, oversize packet of 20 beats, no tlast until beat 20 → cut is set at count=16; data drains; all 20 beats are delivered in order with m_tlast only on beat 20; there is no deadlock.
- Async reset asserted mid-packet (count=7) between clock edges → count, pkt_count, m_tvalid and s_tready go to 0 immediately. After release, s_tready=1 on the first edge and a new 3-beat packet passes correctly.
